// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback formatter.
//
// Captures the memory stage's ALU result, raw read word and control bits on each rising edge.
// Load data is extracted by byte offset and width, then sign- or zero-extended.
// The selected writeback value, destination and write strobe are presented from registers.
// Also flags misaligned loads and counts retired instructions.
//
// Ports:
//   Clock, Reset              rising-edge clock, synchronous active-high reset
//   Stall, Flush              hold all state / insert a bubble (Flush wins over Stall)
//   In_Valid                  incoming slot holds a real instruction
//   R_Enable, R_Width,        load control: enable, width (00 word, 01 half, 10 byte,
//   R_Signed                  11 word), sign-extend select
//   WB_Sel                    writeback source (00 ALU, 01 load, 10 link, 11 ALU)
//   RegWrite, Dest_Reg        register-file write request and destination
//   ALUResult, R_Data,        ALU result / load byte address, raw aligned memory word,
//   PC_Plus_Four              link value
//   WB_Data, WB_Dest,         registered writeback value, destination, write strobe
//   WB_RegWrite
//   WB_Valid, Misaligned      registered slot valid and misaligned-load flag
//   Retire_Count              wrapping count of retired instructions
module mem_wb_stage #(
  parameter int unsigned DATA_W = 32,  // only 32 is supported
  parameter int unsigned REG_AW = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              In_Valid,
  input  logic              R_Enable,
  input  logic [1:0]        R_Width,
  input  logic              R_Signed,
  input  logic [1:0]        WB_Sel,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] Dest_Reg,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] R_Data,
  input  logic [DATA_W-1:0] PC_Plus_Four,
  output logic [DATA_W-1:0] WB_Data,
  output logic [REG_AW-1:0] WB_Dest,
  output logic              WB_RegWrite,
  output logic              WB_Valid,
  output logic              Misaligned,
  output logic [31:0]       Retire_Count
);

  logic [1:0]        off;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic              is_byte;
  logic              is_half;
  logic [DATA_W-1:0] load_data;
  logic              misalign;
  logic [DATA_W-1:0] wb_data_d;
  logic              wb_we_d;

  always_comb begin
    off      = ALUResult[1:0];
    is_byte  = (R_Width == 2'b10);
    is_half  = (R_Width == 2'b01);

    // Little-endian byte lane select.
    case (off)
      2'd0:    sel_byte = R_Data[7:0];
      2'd1:    sel_byte = R_Data[15:8];
      2'd2:    sel_byte = R_Data[23:16];
      default: sel_byte = R_Data[31:24];
    endcase
    sel_half = off[1] ? R_Data[31:16] : R_Data[15:0];

    if (is_byte) begin
      load_data = {{24{R_Signed & sel_byte[7]}}, sel_byte};
    end else if (is_half) begin
      load_data = {{16{R_Signed & sel_half[15]}}, sel_half};
    end else begin
      load_data = R_Data;
    end

    // Byte loads can never be misaligned; width 11 behaves as a word.
    misalign = In_Valid & R_Enable &
               (is_half ? off[0] : (!is_byte && (off != 2'b00)));

    case (WB_Sel)
      2'b01:   wb_data_d = load_data;
      2'b10:   wb_data_d = PC_Plus_Four;
      default: wb_data_d = ALUResult;
    endcase

    wb_we_d = RegWrite & In_Valid & ~misalign & (Dest_Reg != '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      WB_Data      <= '0;
      WB_Dest      <= '0;
      WB_RegWrite  <= 1'b0;
      WB_Valid     <= 1'b0;
      Misaligned   <= 1'b0;
      Retire_Count <= '0;
    end else begin
      // An instruction retires when it leaves the stage, i.e. on the first
      // unstalled edge while it is held, so a long stall counts it once.
      if (WB_Valid && !Stall) begin
        Retire_Count <= Retire_Count + 32'd1;
      end
      if (Flush) begin
        WB_Data     <= '0;
        WB_Dest     <= '0;
        WB_RegWrite <= 1'b0;
        WB_Valid    <= 1'b0;
        Misaligned  <= 1'b0;
      end else if (!Stall) begin
        WB_Data     <= wb_data_d;
        WB_Dest     <= Dest_Reg;
        WB_RegWrite <= wb_we_d;
        WB_Valid    <= In_Valid;
        Misaligned  <= misalign;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed literal cases plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_mem_wb_stage;

  logic        Clock = 1'b0;
  logic        Reset, Stall, Flush, In_Valid, R_Enable, R_Signed, RegWrite;
  logic [1:0]  R_Width, WB_Sel;
  logic [4:0]  Dest_Reg;
  logic [31:0] ALUResult, R_Data, PC_Plus_Four;
  logic [31:0] WB_Data;
  logic [4:0]  WB_Dest;
  logic        WB_RegWrite, WB_Valid, Misaligned;
  logic [31:0] Retire_Count;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .In_Valid(In_Valid),
    .R_Enable(R_Enable), .R_Width(R_Width), .R_Signed(R_Signed), .WB_Sel(WB_Sel),
    .RegWrite(RegWrite), .Dest_Reg(Dest_Reg), .ALUResult(ALUResult), .R_Data(R_Data),
    .PC_Plus_Four(PC_Plus_Four), .WB_Data(WB_Data), .WB_Dest(WB_Dest),
    .WB_RegWrite(WB_RegWrite), .WB_Valid(WB_Valid), .Misaligned(Misaligned),
    .Retire_Count(Retire_Count)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Model state: what the outputs must be after the latest edge.
  logic [31:0] m_data, m_cnt;
  logic [4:0]  m_dest;
  logic        m_we, m_valid, m_mis;

  function automatic logic [31:0] load_fmt(logic [1:0] w, logic sgn, logic [31:0] addr,
                                           logic [31:0] rd);
    logic [31:0] v;
    if (w == 2'b10) begin
      v = (rd >> (8 * addr[1:0])) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (w == 2'b01) begin
      v = (rd >> (16 * addr[1])) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic is_misaligned(logic [1:0] w, logic [31:0] addr);
    int unsigned size;
    size = (w == 2'b10) ? 1 : (w == 2'b01) ? 2 : 4;
    return (addr % size) != 0;
  endfunction

  task automatic model_update();
    logic [31:0] nc;
    logic        mis;
    nc = m_cnt;
    if (Reset) begin
      m_data = '0; m_dest = '0; m_we = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;
    end else begin
      if (m_valid && !Stall) nc = m_cnt + 32'd1;
      if (Flush) begin
        m_data = '0; m_dest = '0; m_we = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
      end else if (!Stall) begin
        mis     = R_Enable && In_Valid && is_misaligned(R_Width, ALUResult);
        m_valid = In_Valid;
        m_mis   = mis;
        m_we    = RegWrite && In_Valid && !mis && (Dest_Reg != 5'd0);
        m_dest  = Dest_Reg;
        if (WB_Sel == 2'b01)      m_data = load_fmt(R_Width, R_Signed, ALUResult, R_Data);
        else if (WB_Sel == 2'b10) m_data = PC_Plus_Four;
        else                      m_data = ALUResult;
      end
      m_cnt = nc;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model WB_Data", WB_Data, m_data);
    check("model WB_Dest", {27'd0, WB_Dest}, {27'd0, m_dest});
    check("model WB_RegWrite", {31'd0, WB_RegWrite}, {31'd0, m_we});
    check("model WB_Valid", {31'd0, WB_Valid}, {31'd0, m_valid});
    check("model Misaligned", {31'd0, Misaligned}, {31'd0, m_mis});
    check("model Retire_Count", Retire_Count, m_cnt);
  endtask

  // One edge: update the model from the inputs present at the edge, then sample #1 later.
  task automatic step();
    @(posedge Clock);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic nop();
    Reset = 0; Stall = 0; Flush = 0; In_Valid = 0; R_Enable = 0; R_Width = 2'b00;
    R_Signed = 0; WB_Sel = 2'b00; RegWrite = 0; Dest_Reg = 0; ALUResult = 0; R_Data = 0;
    PC_Plus_Four = 0;
  endtask

  logic [31:0] c0;

  initial begin
    m_data = '0; m_dest = '0; m_we = 0; m_valid = 0; m_mis = 0; m_cnt = '0;
    nop();
    Reset = 1;
    step();
    check("reset WB_Valid", {31'd0, WB_Valid}, 32'd0);
    check("reset WB_Data", WB_Data, 32'd0);
    check("reset Retire_Count", Retire_Count, 32'd0);

    // Signed byte load from offset 3.
    nop();
    In_Valid = 1; R_Enable = 1; R_Width = 2'b10; R_Signed = 1; WB_Sel = 2'b01;
    ALUResult = 32'h1003; R_Data = 32'h80FF1234; Dest_Reg = 8; RegWrite = 1;
    step();
    check("sbyte WB_Data", WB_Data, 32'hFFFFFF80);
    check("sbyte WB_RegWrite", {31'd0, WB_RegWrite}, 32'd1);
    check("sbyte WB_Dest", {27'd0, WB_Dest}, 32'd8);
    check("sbyte Misaligned", {31'd0, Misaligned}, 32'd0);

    // Unsigned upper half, then a misaligned half.
    R_Width = 2'b01; R_Signed = 0; ALUResult = 32'h2002; R_Data = 32'hBEEF0011;
    step();
    check("uhalf WB_Data", WB_Data, 32'h0000BEEF);
    ALUResult = 32'h2001;
    step();
    check("mis Misaligned", {31'd0, Misaligned}, 32'd1);
    check("mis WB_RegWrite", {31'd0, WB_RegWrite}, 32'd0);
    check("mis WB_Valid", {31'd0, WB_Valid}, 32'd1);

    // Link value, then $0 suppression.
    nop();
    In_Valid = 1; RegWrite = 1; WB_Sel = 2'b10; PC_Plus_Four = 32'h00400010; Dest_Reg = 31;
    step();
    check("link WB_Data", WB_Data, 32'h00400010);
    check("link WB_RegWrite", {31'd0, WB_RegWrite}, 32'd1);
    Dest_Reg = 0;
    step();
    check("x0 WB_RegWrite", {31'd0, WB_RegWrite}, 32'd0);

    // Stall holds outputs; the held instruction retires once.
    nop();
    In_Valid = 1; RegWrite = 1; Dest_Reg = 3; ALUResult = 32'h5;
    step();
    check("stall capture", WB_Data, 32'h5);
    c0 = m_cnt;
    Stall = 1;
    for (int i = 0; i < 3; i++) begin
      ALUResult = $urandom; Dest_Reg = 5'($urandom);
      step();
      check("stall hold WB_Data", WB_Data, 32'h5);
      check("stall hold count", Retire_Count, c0);
    end
    Stall = 0;
    step();
    check("stall release count", Retire_Count, c0 + 32'd1);
    Stall = 1; Flush = 1;
    step();
    check("flush+stall WB_Valid", {31'd0, WB_Valid}, 32'd0);
    check("flush+stall WB_RegWrite", {31'd0, WB_RegWrite}, 32'd0);
    check("flush+stall count", Retire_Count, c0 + 32'd1);

    // Reset in the middle of a valid stream.
    nop();
    In_Valid = 1; RegWrite = 1; Dest_Reg = 9;
    for (int i = 0; i < 10; i++) begin
      ALUResult = $urandom;
      step();
    end
    Reset = 1; R_Enable = 1; WB_Sel = 2'b01; R_Data = 32'hDEADBEEF;
    step();
    check("midreset WB_Data", WB_Data, 32'd0);
    check("midreset WB_Valid", {31'd0, WB_Valid}, 32'd0);
    check("midreset count", Retire_Count, 32'd0);
    nop();
    In_Valid = 1; RegWrite = 1; Dest_Reg = 4; ALUResult = 32'h77;
    step();
    check("post-reset WB_Data", WB_Data, 32'h77);
    check("post-reset WB_Valid", {31'd0, WB_Valid}, 32'd1);
    check("post-reset count", Retire_Count, 32'd0);
    nop();
    step();
    check("post-reset retire", Retire_Count, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      Reset        = ($urandom_range(0, 99) == 0);
      Flush        = ($urandom_range(0, 9) == 0);
      Stall        = ($urandom_range(0, 4) == 0);
      In_Valid     = ($urandom_range(0, 3) != 0);
      R_Enable     = $urandom_range(0, 1);
      R_Width      = 2'($urandom);
      R_Signed     = $urandom_range(0, 1);
      WB_Sel       = 2'($urandom);
      RegWrite     = ($urandom_range(0, 3) != 0);
      Dest_Reg     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ALUResult    = $urandom;
      R_Data       = $urandom;
      PC_Plus_Four = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
